// File: rtl/bcd_seg_scan.sv
// Four-digit multiplexed 7-segment scanner with per-frame BCD snapshot.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zeros on digits 3..1.
module bcd_seg_scan #(
  parameter int unsigned DIV = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] bcd3,
  input  logic [3:0] bcd2,
  input  logic [3:0] bcd1,
  input  logic [3:0] bcd0,
  output logic [3:0] an,
  output logic [6:0] seg
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

  logic [CW-1:0] cnt_p0;
  logic [1:0]    idx_p0;
  logic [15:0]   snap_p0;

  logic          tick;
  logic [1:0]    idx_nxt;
  logic [15:0]   snap_nxt;
  logic [3:0]    digit_nxt;
  logic          blank_nxt;
  logic [6:0]    seg_nxt;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'h40;
      4'd1:    seg_decode = 7'h79;
      4'd2:    seg_decode = 7'h24;
      4'd3:    seg_decode = 7'h30;
      4'd4:    seg_decode = 7'h19;
      4'd5:    seg_decode = 7'h12;
      4'd6:    seg_decode = 7'h02;
      4'd7:    seg_decode = 7'h78;
      4'd8:    seg_decode = 7'h00;
      4'd9:    seg_decode = 7'h10;
      default: seg_decode = 7'h3F;
    endcase
  endfunction

  function automatic logic [3:0] one_cold(input logic [1:0] k);
    one_cold = ~(4'b0001 << k);
  endfunction

  // Next-slot values: the snapshot reloads only when the index wraps 3->0,
  // and the digit shown is taken from that post-load snapshot.
  always_comb begin
    tick      = en && (cnt_p0 == CNT_MAX);
    idx_nxt   = idx_p0 + 2'd1;
    snap_nxt  = (idx_p0 == 2'd3) ? {bcd3, bcd2, bcd1, bcd0} : snap_p0;
    digit_nxt = snap_nxt[{idx_nxt, 2'b00} +: 4];
    blank_nxt = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    case (idx_nxt)
      2'd3:    blank_nxt = (snap_nxt[15:12] == 4'd0);
      2'd2:    blank_nxt = (snap_nxt[15:8]  == 8'd0);
      2'd1:    blank_nxt = (snap_nxt[15:4]  == 12'd0);
      default: blank_nxt = 1'b0;
    endcase
`endif
    seg_nxt   = blank_nxt ? 7'h7F : seg_decode(digit_nxt);
  end

  // Prescaler, index, snapshot and registered display outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_p0  <= '0;
      idx_p0  <= 2'd3;
      snap_p0 <= '0;
      an      <= 4'hF;
      seg     <= 7'h7F;
    end else if (!en) begin
      cnt_p0  <= '0;
      idx_p0  <= 2'd3;
      an      <= 4'hF;
      seg     <= 7'h7F;
    end else if (tick) begin
      cnt_p0  <= '0;
      idx_p0  <= idx_nxt;
      snap_p0 <= snap_nxt;
      an      <= one_cold(idx_nxt);
      seg     <= seg_nxt;
    end else begin
      cnt_p0  <= cnt_p0 + CW'(1);
    end
  end

endmodule

// File: tb/tb_bcd_seg_scan.sv
// Scoreboard bench for bcd_seg_scan (DIV=4): elapsed-cycle reference model,
// directed display checks and randomized digit/enable/reset stimulus.
module tb_bcd_seg_scan;
  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [3:0] bcd3 = 4'd0, bcd2 = 4'd0, bcd1 = 4'd0, bcd0 = 4'd0;
  logic [3:0] an;
  logic [6:0] seg;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [10:0] exp_q[$];
  int          t = 0;
  logic [3:0]  msnap [4] = '{4'd0, 4'd0, 4'd0, 4'd0};
  logic [6:0]  seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  bcd_seg_scan #(.DIV(DIV)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .bcd3(bcd3), .bcd2(bcd2), .bcd1(bcd1), .bcd0(bcd0),
    .an(an), .seg(seg)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [10:0] got, input logic [10:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got an=%b seg=%h, expected an=%b seg=%h",
                  name, got[10:7], got[6:0], exp[10:7], exp[6:0]);
  endtask

  function automatic logic [6:0] ref_seg(input int k);
    bit all_zero = 1'b1;
    for (int j = k; j < 4; j++) if (msnap[j] != 4'd0) all_zero = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    if (k > 0 && all_zero) return 7'h7F;
`endif
    if (all_zero && k == 0) return 7'h40;
    return (msnap[k] > 4'd9) ? 7'h3F : seg_tab[msnap[k]];
  endfunction

  // Expected display after t enabled cycles: slot number = t/DIV,
  // slot 1 shows digit 0, and frames start on slots 1,5,9,...
  function automatic logic [10:0] expect_now();
    int k;
    if (t < DIV) return {4'hF, 7'h7F};
    k = ((t / DIV) - 1) % 4;
    return {4'hF & ~(4'b0001 << k), ref_seg(k)};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t = 0;
      for (int j = 0; j < 4; j++) msnap[j] = 4'd0;
    end else begin
      if (!en) t = 0;
      else begin
        t++;
        if (t % DIV == 0 && ((t / DIV) - 1) % 4 == 0) begin
          msnap[0] = bcd0; msnap[1] = bcd1; msnap[2] = bcd2; msnap[3] = bcd3;
        end
      end
      exp_q.push_back(expect_now());
    end
  end

  always @(negedge clk) begin
    if (exp_q.size() > 0) check("scan", {an, seg}, exp_q.pop_front());
  end

  task automatic set_bcd(input logic [3:0] d3, d2, d1, d0);
    bcd3 = d3; bcd2 = d2; bcd1 = d1; bcd0 = d0;
  endtask

  task automatic wait_an(input logic [3:0] target, output bit found);
    found = 1'b0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (an == target) begin found = 1'b1; break; end
    end
    if (!found) begin
      total_cnt++;
      $display("FAIL wait_an: an=%b never reached %b", an, target);
    end
  endtask

  task automatic rst_pulse();
    @(negedge clk); #2;
    rst_n = 1'b0; #1;
    check("async_reset", {an, seg}, {4'hF, 7'h7F});
    #1 rst_n = 1'b1;
  endtask

  initial begin
    bit found;
    repeat (2) @(negedge clk);
    #1 check("reset_state", {an, seg}, {4'hF, 7'h7F});

    // Release reset with 1,2,3,4 and scan
    @(negedge clk);
    set_bcd(4'd1, 4'd2, 4'd3, 4'd4);
    en = 1'b1; rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1 check("first_tick", {an, seg}, {4'b1110, 7'h19});
    repeat (5) @(posedge clk);
    #1 check("digit1", {an, seg}, {4'b1101, 7'h30});
    set_bcd(4'd9, 4'd9, 4'd9, 4'd9);
    repeat (4) @(posedge clk);
    #1 check("held_digit2", {an, seg}, {4'b1011, 7'h24});
    repeat (8) @(posedge clk);
    #1 check("new_frame", {an, seg}, {4'b1110, 7'h10});

    // Invalid BCD on digit 1
    set_bcd(4'd1, 4'd2, 4'hC, 4'd4);
    repeat (16) @(negedge clk);
    wait_an(4'b1101, found);
    if (found) check("invalid_bcd", {an, seg}, {4'b1101, 7'h3F});

    // Leading-zero handling
    set_bcd(4'd0, 4'd0, 4'd0, 4'd7);
    repeat (16) @(negedge clk);
    wait_an(4'b0111, found);
`ifdef LEADING_ZERO_BLANK_EN
    if (found) check("lz_digit3", {an, seg}, {4'b0111, 7'h7F});
`else
    if (found) check("lz_digit3", {an, seg}, {4'b0111, 7'h40});
`endif
    wait_an(4'b1110, found);
    if (found) check("lz_digit0", {an, seg}, {4'b1110, 7'h78});
    set_bcd(4'd0, 4'd0, 4'd0, 4'd0);
    repeat (16) @(negedge clk);
    wait_an(4'b1110, found);
    if (found) check("zero_digit0", {an, seg}, {4'b1110, 7'h40});

    // Disable mid-frame, then reset mid-digit
    set_bcd(4'd5, 4'd6, 4'd8, 4'd3);
    repeat (22) @(negedge clk);
    #1 en = 1'b0;
    @(posedge clk);
    #1 check("en_drop", {an, seg}, {4'hF, 7'h7F});
    @(negedge clk); #1 en = 1'b1;
    repeat (10) @(negedge clk);
    rst_pulse();

    // Randomized digits, enable drops and reset pulses
    repeat (300) begin
      int r;
      @(negedge clk); #1;
      r = $urandom_range(0, 19);
      if (r < 2) begin
        en = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        #1 en = 1'b1;
      end else if (r == 2) begin
        rst_pulse();
      end else begin
        bcd3 = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        bcd2 = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        bcd1 = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        bcd0 = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      end
      repeat ($urandom_range(1, 10)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    #1 $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/bcd_seg_scan.md
BCD_SEG_SCAN -- requirements
Module: bcd_seg_scan

Interface
REQ-001 SHALL have parameter DIV, default 50000, meaning clock cycles per digit slot; legal range 2..2^20.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port en, input, 1, scan enable.
REQ-005 SHALL have ports bcd3, bcd2, bcd1, bcd0, input, 4 each, BCD digits from the binary-to-BCD stage; bcd3 is most significant.
REQ-006 SHALL have port an, output, 4, active-low digit select; an[k] selects digit k.
REQ-007 SHALL have port seg, output, 7, active-low segments {g,f,e,d,c,b,a}.

Function
REQ-008 SHALL run a prescaler counting 0..DIV-1 while en=1; tick is asserted in the cycle where the count equals DIV-1, and the count then wraps to 0.
REQ-009 SHALL hold a 2-bit digit index; on each tick the index advances 3->0->1->2->3->0 and wraps.
REQ-010 SHALL capture all four bcd inputs into a frame snapshot register on a tick where the index moves 3->0; the snapshot is otherwise held.
REQ-011 SHALL drive registered outputs: on each tick edge, an and seg update in the same edge as the index, using the new index and new snapshot; outputs have no combinational path from inputs.
REQ-012 SHALL drive an as the one-cold code of the index: 0->1110, 1->1101, 2->1011, 3->0111.
REQ-013 SHALL decode seg from the selected snapshot digit: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex).
REQ-014 SHALL display a dash (seg=3F) for any digit value 10..15.
REQ-015 SHALL hold each digit for exactly DIV cycles, giving a full frame of 4*DIV cycles.
REQ-016 SHALL synchronously return prescaler, index, an and seg to their reset values in the first edge where en=0, and hold them there while en=0.
REQ-017 SHALL keep the snapshot unchanged while en=0.
REQ-018 SHALL not show input changes mid-frame; such changes appear only from the next 3->0 transition.

Reset
REQ-019 SHALL, while rst_n=0, immediately force prescaler=0, index=3, snapshot=0, an=1111 and seg=7F, independent of clk.
REQ-020 SHALL, after rst_n deasserts with en=1, produce the first tick DIV cycles later; that tick loads the snapshot and selects digit 0.
REQ-021 SHALL abandon any partial frame on reset mid-operation, with no residual digit shown.

Configuration
REQ-022 SHALL support macro LEADING_ZERO_BLANK_EN.
REQ-023 SHALL, with LEADING_ZERO_BLANK_EN defined, show seg=7F for digit k (k=3,2,1) when snapshot digits k..3 are all zero; digit 0 is never blanked; a value of 10..15 counts as nonzero.
REQ-024 SHALL, with LEADING_ZERO_BLANK_EN undefined, show every digit per REQ-013/REQ-014.

Verification
REQ-025 SHALL cover reset: with DIV=4, rst_n low -> an=1111, seg=7F; release with en=1 -> an=1110 on the 4th rising edge after release.
REQ-026 SHALL cover scanning: DIV=4, bcd3..0=1,2,3,4 -> an/seg sequence 1110/19, 1101/30, 1011/24, 0111/79, each held 4 cycles, then repeats.
REQ-027 SHALL cover snapshot: inputs changed to 9,9,9,9 while an=1101 -> digits 2 and 3 still show 24 and 79; the next frame shows 10 on all digits.
REQ-028 SHALL cover invalid BCD: bcd1=C -> seg=3F while an=1101.
REQ-029 SHALL cover the macro: with it defined, inputs 0,0,0,7 -> digits 3, 2 and 1 show 7F and digit 0 shows 78, while 0,0,0,0 shows 40 on digit 0; with it undefined, zeros show 40.
REQ-030 SHALL cover disable and reset: en dropped mid-frame -> an=1111, seg=7F after the next edge; rst_n pulsed low mid-digit -> an=1111 with no clock edge.
